// File: rtl/polaris_ifetch_rom_bridge.sv
// Instruction-fetch slave for the PolarisCPU I port. Requests are served from a
// 16-bit boot ROM one halfword at a time, with a programmable number of wait
// states per halfword. Two halfwords are assembled into each 32-bit word.
// Requests that miss the window, are misaligned, or use an unsupported size
// are still acknowledged, with zero data and ierr_o set, so a fetch can never
// stall the CPU.
module polaris_ifetch_rom_bridge #(
  parameter logic [63:0] BASE   = 64'hFFFF_FFFF_FFFF_FE00,
  parameter int          ROM_AW = 8,
  parameter int          WAIT   = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [63:0]       iadr_i,
  input  logic [1:0]        isiz_i,
  output logic              iack_o,
  output logic [31:0]       idat_o,
  output logic              ierr_o,
  output logic              rom_cs_o,
  output logic [ROM_AW-1:0] rom_adr_o,
  input  logic [15:0]       rom_dat_i
);

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RDLO = 2'b01,
    ST_RDHI = 2'b10,
    ST_ACK  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       lo_q, lo_d;
  logic              word_q, word_d;
  logic              bad_q, bad_d;
  logic              iack_q, iack_d;
  logic [31:0]       idat_q, idat_d;
  logic              ierr_q, ierr_d;
  logic              cs_q, cs_d;
  logic [ROM_AW-1:0] adr_q, adr_d;

  logic              hit_s;
  logic              bad_req_s;

  // Classify the request presented on the bus; only consulted in IDLE.
  always_comb begin
    hit_s     = (iadr_i[63:ROM_AW+1] == BASE[63:ROM_AW+1]);
    bad_req_s = 1'b0;
    if (!hit_s) begin
      bad_req_s = 1'b1;
    end else begin
      case (isiz_i)
        2'b01:   bad_req_s = iadr_i[0];
        2'b10:   bad_req_s = (iadr_i[1:0] != 2'b00);
        2'b11:   bad_req_s = 1'b1;
        default: bad_req_s = 1'b0;
      endcase
    end
  end

  // Next-state and registered-output decode. A rejected request spends one
  // cycle in RDLO with the chip select off, so an error ack arrives in the same
  // cycle as a zero-wait halfword ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    word_d  = word_q;
    bad_d   = bad_q;
    iack_d  = 1'b0;
    idat_d  = idat_q;
    ierr_d  = ierr_q;
    cs_d    = cs_q;
    adr_d   = adr_q;
    case (state_q)
      ST_IDLE: begin
        if (isiz_i != 2'b00) begin
          word_d  = (isiz_i == 2'b10);
          state_d = ST_RDLO;
          if (bad_req_s) begin
            bad_d = 1'b1;
            cnt_d = 4'd0;
            cs_d  = 1'b0;
          end else begin
            bad_d = 1'b0;
            cnt_d = WAIT_C;
            cs_d  = 1'b1;
            adr_d = iadr_i[ROM_AW:1];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RDLO: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (bad_q) begin
          idat_d  = 32'h0000_0000;
          ierr_d  = 1'b1;
          iack_d  = 1'b1;
          state_d = ST_ACK;
        end else begin
          lo_d = rom_dat_i;
          if (word_q) begin
            // Word addresses are 4-byte aligned, so the low index is even
            // and index+1 never wraps.
            adr_d   = adr_q + ROM_AW'(1);
            cnt_d   = WAIT_C;
            state_d = ST_RDHI;
          end else begin
            idat_d  = {16'h0000, rom_dat_i};
            ierr_d  = 1'b0;
            cs_d    = 1'b0;
            iack_d  = 1'b1;
            state_d = ST_ACK;
          end
        end
      end
      ST_RDHI: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          idat_d  = {rom_dat_i, lo_q};
          ierr_d  = 1'b0;
          cs_d    = 1'b0;
          iack_d  = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      lo_q    <= 16'h0000;
      word_q  <= 1'b0;
      bad_q   <= 1'b0;
      iack_q  <= 1'b0;
      idat_q  <= 32'h0000_0000;
      ierr_q  <= 1'b0;
      cs_q    <= 1'b0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      word_q  <= word_d;
      bad_q   <= bad_d;
      iack_q  <= iack_d;
      idat_q  <= idat_d;
      ierr_q  <= ierr_d;
      cs_q    <= cs_d;
      adr_q   <= adr_d;
    end
  end

  assign iack_o    = iack_q;
  assign idat_o    = idat_q;
  assign ierr_o    = ierr_q;
  assign rom_cs_o  = cs_q;
  assign rom_adr_o = adr_q;

endmodule

// File: tb/tb_polaris_ifetch_rom_bridge.sv
// Directed bench for polaris_ifetch_rom_bridge: one instance with one wait state
// and one with none, each fed from its own ROM array.
module tb_polaris_ifetch_rom_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] iadr1, iadr0;
  logic [1:0]  isiz1, isiz0;
  logic        ack1, err1, cs1, ack0, err0, cs0;
  logic [31:0] dat1, dat0;
  logic [7:0]  adr1, adr0;
  logic [15:0] rd1, rd0;
  logic [15:0] rom1 [256];
  logic [15:0] rom0 [256];

  assign rd1 = rom1[adr1];
  assign rd0 = rom0[adr0];

  polaris_ifetch_rom_bridge #(.BASE(64'hFFFF_FFFF_FFFF_FE00), .ROM_AW(8), .WAIT(1)) u_w1 (
    .clk_i(clk), .reset_i(rst_n), .iadr_i(iadr1), .isiz_i(isiz1),
    .iack_o(ack1), .idat_o(dat1), .ierr_o(err1),
    .rom_cs_o(cs1), .rom_adr_o(adr1), .rom_dat_i(rd1));

  polaris_ifetch_rom_bridge #(.BASE(64'hFFFF_FFFF_FFFF_FE00), .ROM_AW(8), .WAIT(0)) u_w0 (
    .clk_i(clk), .reset_i(rst_n), .iadr_i(iadr0), .isiz_i(isiz0),
    .iack_o(ack0), .idat_o(dat0), .ierr_o(err0),
    .rom_cs_o(cs0), .rom_adr_o(adr0), .rom_dat_i(rd0));

  // sel=0 observes the WAIT=1 instance, sel=1 the WAIT=0 instance
  bit          sel = 1'b0;
  logic        m_iack, m_err, m_cs;
  logic [31:0] m_dat;
  logic [7:0]  m_adr;
  assign m_iack = sel ? ack0 : ack1;
  assign m_err  = sel ? err0 : err1;
  assign m_cs   = sel ? cs0  : cs1;
  assign m_dat  = sel ? dat0 : dat1;
  assign m_adr  = sel ? adr0 : adr1;

  int n_tests = 0;
  int n_fail  = 0;

  int          ack_cyc;
  bit          saw_cs;
  logic [7:0]  adr_c1, adr_last;
  logic [31:0] ack_dat;
  logic        ack_err;

  typedef struct {
    logic [63:0] adr;
    logic [1:0]  siz;
    logic [31:0] dat;
    logic        err;
    int          lat;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [1:0] z);
    if (sel) begin
      iadr0 = a;
      isiz0 = z;
    end else begin
      iadr1 = a;
      isiz1 = z;
    end
  endtask

  // Present one request for a single cycle, then withdraw it and wait for the ack.
  task automatic run_txn(input bit s, input logic [63:0] adr, input logic [1:0] siz);
    sel = s;
    @(posedge clk); #1;
    drive(adr, siz);
    ack_cyc = -1;
    saw_cs  = 1'b0;
    for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
      @(posedge clk); #1;
      drive(adr, 2'b00);
      @(negedge clk);
      if (c == 1) adr_c1 = m_adr;
      if (m_cs) begin
        saw_cs   = 1'b1;
        adr_last = m_adr;
      end
      if (m_iack) begin
        ack_cyc = c;
        ack_dat = m_dat;
        ack_err = m_err;
      end
    end
    if (ack_cyc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: no iack within 40 cycles for adr %0h", adr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("single_pulse", {63'd0, m_iack}, 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    int          n_ack;
    bit          step;
    bit          any_ack;
    bit          any_cs;
    logic [31:0] exp5 [3];
    int          cyc5 [3];

    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      rom1[i] = {b ^ 8'hA5, b};
      rom0[i] = {b ^ 8'hA5, b};
    end
    rom1[8'h80] = 16'h0513;
    rom1[8'h81] = 16'h0010;
    rom0[8'h81] = 16'hBEEF;

    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FF00, 2'b10, 32'h0010_0513, 1'b0, 5};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FF04, 2'b10, 32'h2683_2782, 1'b0, 5};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FF06, 2'b01, 32'h0000_2683, 1'b0, 3};
    vecs[3]  = '{64'hFFFF_FFFF_FFFF_FE00, 2'b10, 32'hA401_A500, 1'b0, 5};
    vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFFC, 2'b10, 32'h5AFF_5BFE, 1'b0, 5};
    vecs[5]  = '{64'h0000_0000_0000_1000, 2'b10, 32'h0000_0000, 1'b1, 2};
    vecs[6]  = '{64'hFFFF_FFFF_FFFF_FF02, 2'b10, 32'h0000_0000, 1'b1, 2};
    vecs[7]  = '{64'hFFFF_FFFF_FFFF_FF00, 2'b11, 32'h0000_0000, 1'b1, 2};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FF01, 2'b01, 32'h0000_0000, 1'b1, 2};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_FDFE, 2'b01, 32'h0000_0000, 1'b1, 2};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_FE02, 2'b01, 32'h0000_A401, 1'b0, 3};

    rst_n = 1'b0;
    iadr1 = 64'd0; isiz1 = 2'b00;
    iadr0 = 64'd0; isiz0 = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_iack",  {63'd0, ack1}, 64'd0);
    check("rst_idat",  {32'd0, dat1}, 64'd0);
    check("rst_ierr",  {63'd0, err1}, 64'd0);
    check("rst_cs",    {63'd0, cs1},  64'd0);
    check("rst_adr",   {56'd0, adr1}, 64'd0);
    check("rst_iack0", {63'd0, ack0}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Word fetch with explicit ROM address sequence
    run_txn(1'b0, 64'hFFFF_FFFF_FFFF_FF00, 2'b10);
    check("t2_adr_lo", {56'd0, adr_c1},   64'h80);
    check("t2_adr_hi", {56'd0, adr_last}, 64'h81);

    // Table of single transactions on the one-wait-state instance
    for (int i = 0; i < 11; i++) begin
      run_txn(1'b0, vecs[i].adr, vecs[i].siz);
      check($sformatf("v%0d_lat", i), 64'(ack_cyc), 64'(vecs[i].lat));
      check($sformatf("v%0d_dat", i), {32'd0, ack_dat}, {32'd0, vecs[i].dat});
      check($sformatf("v%0d_err", i), {63'd0, ack_err}, {63'd0, vecs[i].err});
      check($sformatf("v%0d_cs", i),  {63'd0, saw_cs},  {63'd0, ~vecs[i].err});
    end

    // Zero wait states
    run_txn(1'b1, 64'hFFFF_FFFF_FFFF_FF02, 2'b01);
    check("w0_half_lat", 64'(ack_cyc), 64'd2);
    check("w0_half_dat", {32'd0, ack_dat}, 64'h0000_BEEF);
    run_txn(1'b1, 64'hFFFF_FFFF_FFFF_FF00, 2'b10);
    check("w0_word_lat", 64'(ack_cyc), 64'd3);
    check("w0_word_dat", {32'd0, ack_dat}, 64'hBEEF_2580);
    run_txn(1'b1, 64'h0000_0000_0000_1000, 2'b10);
    check("w0_bad_lat", 64'(ack_cyc), 64'd2);
    check("w0_bad_err", {63'd0, ack_err}, 64'd1);

    // Request held across acks, address stepping after each ack
    sel     = 1'b0;
    exp5[0] = 32'h0010_0513; exp5[1] = 32'h2683_2782; exp5[2] = 32'h2085_2184;
    cyc5[0] = 5; cyc5[1] = 11; cyc5[2] = 17;
    n_ack   = 0;
    step    = 1'b0;
    @(posedge clk); #1;
    a = 64'hFFFF_FFFF_FFFF_FF00;
    drive(a, 2'b10);
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      if (step) begin
        a    = a + 64'd4;
        drive(a, 2'b10);
        step = 1'b0;
      end
      @(negedge clk);
      if (m_iack) begin
        if (n_ack < 3) begin
          check($sformatf("b2b_cyc%0d", n_ack), 64'(c), 64'(cyc5[n_ack]));
          check($sformatf("b2b_dat%0d", n_ack), {32'd0, m_dat}, {32'd0, exp5[n_ack]});
        end
        n_ack++;
        step = 1'b1;
      end
    end
    @(posedge clk); #1;
    drive(a, 2'b00);
    check("b2b_count", 64'(n_ack), 64'd3);
    any_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_ack |= m_iack;
    end
    check("b2b_no_extra", {63'd0, any_ack}, 64'd0);

    // Reset asserted while the upper halfword is being read
    sel = 1'b0;
    @(posedge clk); #1;
    drive(64'hFFFF_FFFF_FFFF_FF04, 2'b10);
    @(posedge clk); #1;
    drive(64'hFFFF_FFFF_FFFF_FF04, 2'b00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_cs_before", {63'd0, m_cs}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_iack", {63'd0, m_iack}, 64'd0);
    check("mid_rst_cs",   {63'd0, m_cs},   64'd0);
    check("mid_rst_idat", {32'd0, m_dat},  64'd0);
    check("mid_rst_adr",  {56'd0, m_adr},  64'd0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    any_ack = 1'b0;
    any_cs  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_ack |= m_iack;
      any_cs  |= m_cs;
    end
    check("post_rst_no_ack", {63'd0, any_ack}, 64'd0);
    check("post_rst_no_cs",  {63'd0, any_cs},  64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
